// File: rtl/us_pkg.sv
// Shared types and default timing for the ultrasonic transmit chain.
// Timer width and the sequencer state encoding live here.
package us_pkg;

   localparam int CLK_HZ = 50_000_000;
   localparam int CARRIER_HZ = 40_000;
   localparam int CNT_W = 22;
   localparam int DEF_CARRIER_HALF = CLK_HZ / CARRIER_HZ / 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BURST   = 3'd1,
      ST_BLANK   = 3'd2,
      ST_LISTEN  = 3'd3,
      ST_HOLDOFF = 3'd4
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/us_carrier_gen.sv
// 40 kHz carrier: complementary legs that start high on the first
// enabled cycle and toggle every HALF clocks; both legs low when idle.
module us_carrier_gen
   import us_pkg::*;
#(
   parameter int HALF = DEF_CARRIER_HALF
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic en,
   output logic tx_p,
   output logic tx_n
);

   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic tx_p_q, tx_p_d;
   logic tx_n_q, tx_n_d;

   // One leg is always high while running, so the legs double as the run flag
   always_comb begin
      cnt_d  = '0;
      tx_p_d = 1'b0;
      tx_n_d = 1'b0;
      if (en) begin
         if (!(tx_p_q || tx_n_q)) begin
            tx_p_d = 1'b1;
         end else if (cnt_q == HALF_END) begin
            tx_p_d = ~tx_p_q;
            tx_n_d = tx_p_q;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tx_p_d = tx_p_q;
            tx_n_d = tx_n_q;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         cnt_q  <= '0;
         tx_p_q <= 1'b0;
         tx_n_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tx_p_q <= tx_p_d;
         tx_n_q <= tx_n_d;
      end
   end

   assign tx_p = tx_p_q;
   assign tx_n = tx_n_q;

endmodule

// File: rtl/us_tx_sequencer.sv
// Measurement sequencer: burst, ringdown blanking, listen window and
// holdoff to a fixed repetition period, with echo/timeout flags.
module us_tx_sequencer
   import us_pkg::*;
#(
   parameter int CARRIER_HALF = DEF_CARRIER_HALF,
   parameter int BURST_CYCLES = 8,
   parameter int BLANK_CLKS   = 50000,
   parameter int LISTEN_CLKS  = 1900000,
   parameter int PERIOD_CLKS  = 3000000
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic en,
   input  logic start,
   input  logic pulse_r,
   output logic tx_p,
   output logic tx_n,
   output logic pulse_t,
   output logic listening,
   output logic echo_seen,
   output logic timeout,
   output logic busy
);

   // Every phase ends at a fixed offset of the period timer
   localparam int BURST_LEN = 2 * BURST_CYCLES * CARRIER_HALF;
   localparam logic [CNT_W-1:0] BURST_END  = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] BLANK_END  =
      CNT_W'(BURST_LEN + BLANK_CLKS - 1);
   localparam logic [CNT_W-1:0] LISTEN_END =
      CNT_W'(BURST_LEN + BLANK_CLKS + LISTEN_CLKS - 1);
   localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(PERIOD_CLKS - 1);

   state_t state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic r1_q, r2_q;
   logic rise;
   logic pulse_t_q, pulse_t_d;
   logic listening_q, listening_d;
   logic echo_q, echo_d;
   logic tout_q, tout_d;
   logic busy_q, busy_d;

   assign rise = r1_q & ~r2_q;

   always_comb begin
      state_d = state_q;
      echo_d  = 1'b0;
      tout_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en || start) state_d = ST_BURST;
         end
         ST_BURST: begin
            if (tmr_q == BURST_END) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (tmr_q == BLANK_END) state_d = ST_LISTEN;
         end
         ST_LISTEN: begin
            if (rise) begin
               echo_d  = 1'b1;
               state_d = ST_HOLDOFF;
            end else if (tmr_q == LISTEN_END) begin
               tout_d  = 1'b1;
               state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (tmr_q >= HOLD_END) state_d = en ? ST_BURST : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      tmr_d = (state_d == ST_BURST && state_q != ST_BURST)
            ? '0 : sat_inc(tmr_q);
      pulse_t_d   = (state_d == ST_BURST);
      listening_d = (state_d == ST_LISTEN);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         r1_q        <= 1'b0;
         r2_q        <= 1'b0;
         pulse_t_q   <= 1'b0;
         listening_q <= 1'b0;
         echo_q      <= 1'b0;
         tout_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         r1_q        <= pulse_r;
         r2_q        <= r1_q;
         pulse_t_q   <= pulse_t_d;
         listening_q <= listening_d;
         echo_q      <= echo_d;
         tout_q      <= tout_d;
         busy_q      <= busy_d;
      end
   end

   us_carrier_gen #(
      .HALF (CARRIER_HALF)
   ) u_carrier (
      .CLK  (CLK),
      .RSTn (RSTn),
      .en   (pulse_t_d),
      .tx_p (tx_p),
      .tx_n (tx_n)
   );

   assign pulse_t   = pulse_t_q;
   assign listening = listening_q;
   assign echo_seen = echo_q;
   assign timeout   = tout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_us_tx_sequencer.sv
// Bench for us_tx_sequencer: directed measurement table, reset corner
// and random traffic against a time-since-burst reference model.
module tb_us_tx_sequencer;

   localparam int CH = 4;
   localparam int BC = 2;
   localparam int BL = 10;
   localparam int LI = 50;
   localparam int PE = 100;
   localparam int BLEN = 2 * BC * CH;
   localparam int L_LO = BLEN + BL;
   localparam int L_HI = BLEN + BL + LI;

   logic CLK = 1'b0;
   logic RSTn, en, start, pulse_r;
   logic tx_p, tx_n, pulse_t, listening, echo_seen, timeout, busy;

   always #5 CLK = ~CLK;

   us_tx_sequencer #(
      .CARRIER_HALF (CH),
      .BURST_CYCLES (BC),
      .BLANK_CLKS   (BL),
      .LISTEN_CLKS  (LI),
      .PERIOD_CLKS  (PE)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .en        (en),
      .start     (start),
      .pulse_r   (pulse_r),
      .tx_p      (tx_p),
      .tx_n      (tx_n),
      .pulse_t   (pulse_t),
      .listening (listening),
      .echo_seen (echo_seen),
      .timeout   (timeout),
      .busy      (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;
   logic [6:0] last_out;

   // model: busy flag, cycles since burst start, t of detected echo
   bit m_busy = 1'b0;
   int m_t = 0;
   int m_echo = -1;
   bit p1 = 1'b0;
   bit p2 = 1'b0;

   typedef struct {
      int en_until;
      int pr_lo;
      int pr_hi;
      int start2;
      int x_echo;
      int x_tout;
      int x_next;
      int x_idle;
   } vec_t;

   vec_t vt[8];
   int ev_e, ev_t, ev_n, ev_i;
   bit prev_pt;
   int nb;
   logic [15:0] pat;

   function automatic bit in_listen(int t, int ec);
      return t >= L_LO && t < L_HI && !(ec >= 0 && t > ec);
   endfunction

   function automatic logic [6:0] exp_out();
      bit pt, tp, tn, li, es, to;
      if (!m_busy) return 7'd0;
      pt = m_t < BLEN;
      tp = pt && ((m_t / CH) % 2 == 0);
      tn = pt && !tp;
      li = in_listen(m_t, m_echo);
      es = m_echo >= 0 && m_t == m_echo + 1;
      to = m_echo < 0 && m_t == L_HI;
      return {tp, tn, pt, li, es, to, 1'b1};
   endfunction

   task automatic model_step();
      if (!RSTn) begin
         m_busy = 1'b0;
         p1 = 1'b0;
         p2 = 1'b0;
         return;
      end
      if (m_busy) begin
         if (in_listen(m_t, m_echo) && p1 && !p2 && m_echo < 0)
            m_echo = m_t;
         if (m_t >= PE - 1) begin
            if (en) begin
               m_t = 0;
               m_echo = -1;
            end else begin
               m_busy = 1'b0;
            end
         end else begin
            m_t++;
         end
      end else if (en || start) begin
         m_busy = 1'b1;
         m_t = 0;
         m_echo = -1;
      end
      p2 = p1;
      p1 = pulse_r;
   endtask

   task automatic cycle(input string tag, input bit chk);
      logic [6:0] e, g;
      @(negedge CLK);
      g = {tx_p, tx_n, pulse_t, listening, echo_seen, timeout, busy};
      last_out = g;
      if (chk) begin
         e = exp_out();
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc_n, g, e);
         end
      end
      model_step();
      cyc_n++;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   initial begin
      // en_until, pr_lo, pr_hi, start2, echo, tout, next, idle
      vt[0] = '{0, -10, -10, -100, -1, 76, -1, 100};
      vt[1] = '{0, 46, 60, -100, 48, -1, -1, 100};
      vt[2] = '{105, 46, 60, -100, 48, 176, 100, 200};
      vt[3] = '{0, 18, 22, -100, -1, 76, -1, 100};
      vt[4] = '{0, 74, 90, -100, 76, -1, -1, 100};
      vt[5] = '{0, 24, 40, -100, -1, 76, -1, 100};
      vt[6] = '{0, 25, 40, -100, 27, -1, -1, 100};
      vt[7] = '{0, -10, -10, 40, -1, 76, -1, 100};

      RSTn = 1'b0;
      en = 1'b0;
      start = 1'b0;
      pulse_r = 1'b0;
      #1;
      repeat (3) cycle("pre", 1'b0);
      RSTn = 1'b1;
      cycle("reset_state", 1'b1);
      check("reset_outs", int'(last_out), 0);

      for (int i = 0; i < 8; i++) begin
         ev_e = -1;
         ev_t = -1;
         ev_n = -1;
         ev_i = -1;
         prev_pt = 1'b0;
         for (int t = -1; t < 210; t++) begin
            start = (t == -1) || (t == vt[i].start2);
            en = vt[i].en_until > 0 && t < vt[i].en_until;
            pulse_r = t >= vt[i].pr_lo && t < vt[i].pr_hi;
            cycle($sformatf("vec%0d", i), 1'b1);
            if (last_out[2] && ev_e < 0) ev_e = t;
            if (last_out[1] && ev_t < 0) ev_t = t;
            if (t > 0 && last_out[4] && !prev_pt && ev_n < 0) ev_n = t;
            if (t >= 0 && !last_out[0] && ev_i < 0) ev_i = t;
            prev_pt = last_out[4];
         end
         start = 1'b0;
         en = 1'b0;
         pulse_r = 1'b0;
         check($sformatf("vec%0d_echo_t", i), ev_e, vt[i].x_echo);
         check($sformatf("vec%0d_tout_t", i), ev_t, vt[i].x_tout);
         check($sformatf("vec%0d_next_t", i), ev_n, vt[i].x_next);
         check($sformatf("vec%0d_idle_t", i), ev_i, vt[i].x_idle);
      end

      start = 1'b1;
      cycle("rst_seq", 1'b1);
      start = 1'b0;
      repeat (6) cycle("rst_seq", 1'b1);
      RSTn = 1'b0;
      cycle("rst_seq", 1'b1);
      RSTn = 1'b1;
      cycle("rst_after", 1'b1);
      check("rst_mid_burst_outs", int'(last_out), 0);
      start = 1'b1;
      cycle("rst_restart", 1'b1);
      start = 1'b0;
      nb = 0;
      pat = '0;
      for (int k = 0; k < 30; k++) begin
         cycle("rst_restart", 1'b1);
         if (last_out[4]) begin
            if (nb < 16) pat[15 - nb] = last_out[6];
            nb++;
         end
      end
      check("burst_len", nb, 16);
      check("tx_p_pattern", int'(pat), 32'h0000F0F0);
      repeat (100) cycle("rst_tail", 1'b1);

      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) en = ~en;
         start = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) pulse_r = ~pulse_r;
         RSTn = !($urandom_range(0, 1999) == 0);
         cycle("rand", 1'b1);
      end
      RSTn = 1'b1;
      en = 1'b0;
      start = 1'b0;
      repeat (5) cycle("drain", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/us_tx_sequencer.md
Name: us_tx_sequencer

Overview:
- Upstream stage of the ultrasonic ranging chain: generates the 40 kHz transmit burst that drives the transducer and the pulse_t marker consumed by the echo-gating stage.
- Sequences each measurement: burst, blanking (ringdown), listen window with timeout, and holdoff to a fixed repetition period.
- Qualifies the raw echo (pulse_r) inside the listen window and flags echo/timeout per measurement.

Parameters:
- CARRIER_HALF, 625, clocks per carrier half-period (50 MHz / 40 kHz / 2)
- BURST_CYCLES, 8, full carrier periods per burst
- BLANK_CLKS, 50000, clocks after burst during which echo edges are ignored (1 ms)
- LISTEN_CLKS, 1900000, listen window length in clocks (38 ms, ≈6.5 m)
- PERIOD_CLKS, 3000000, burst-start to burst-start period (60 ms); must be ≥ 2*BURST_CYCLES*CARRIER_HALF + BLANK_CLKS + LISTEN_CLKS + 1
- CNT_W, 22, width of all internal timers

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset, synchronous, active-low
- en  in  1  auto-repeat enable; level
- start  in  1  single-shot request; 1-cycle pulse, honoured in IDLE only
- pulse_r  in  1  raw echo comparator output, asynchronous
- tx_p  out  1  carrier drive, positive leg
- tx_n  out  1  carrier drive, negative leg
- pulse_t  out  1  high for exactly the burst duration
- listening  out  1  high while in LISTEN
- echo_seen  out  1  1-cycle pulse on qualified echo rising edge
- timeout  out  1  1-cycle pulse when LISTEN expires without echo
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (RSTn=0 at CLK edge): state IDLE; all outputs 0; all timers 0; sync flops 0. Applies mid-burst: tx_p/tx_n drop to 0 on the next edge.
- pulse_r through 2-flop synchroniser (r1, r2); rising edge = r1 & ~r2.
- States: IDLE, BURST, BLANK, LISTEN, HOLDOFF; all outputs registered.
- IDLE: if en or start -> BURST next cycle; period timer cleared to 0 on entry to BURST.
- BURST: pulse_t=1; tx_p=1 on first BURST cycle, toggles every CARRIER_HALF clocks; tx_n=~tx_p. Lasts exactly 2*BURST_CYCLES*CARRIER_HALF clocks -> BLANK. Outside BURST tx_p=tx_n=0, pulse_t=0.
- BLANK: lasts BLANK_CLKS clocks; echo edges ignored -> LISTEN.
- LISTEN: listening=1; up to LISTEN_CLKS clocks. Qualified rising edge -> echo_seen=1 for one cycle, go HOLDOFF. Expiry (last LISTEN cycle, no edge) -> timeout=1 for one cycle, go HOLDOFF. Edge on final LISTEN cycle: echo_seen wins, no timeout.
- HOLDOFF: wait until period timer ≥ PERIOD_CLKS-1, then BURST if en else IDLE. Minimum 1 cycle in HOLDOFF.
- Period timer: increments every cycle from BURST entry, saturates at all-ones, never wraps.
- en deasserted mid-measurement: current measurement completes; return to IDLE from HOLDOFF.
- start outside IDLE ignored (not queued).
- busy = (state != IDLE).

Decomposition:
- Shared package us_pkg: state encoding constants, default timing constants (CLK_HZ, CARRIER_HZ), CNT_W.
- One sub-module: us_carrier_gen (half-period counter + toggle flop, enable input, tx_p/tx_n outputs); FSM and timers stay in the top.

Test Plan:
- Small params (CARRIER_HALF=4, BURST_CYCLES=2, BLANK_CLKS=10, LISTEN_CLKS=50, PERIOD_CLKS=100); start pulse from IDLE -> pulse_t high exactly 16 cycles starting the cycle after start; tx_p pattern 1111000011110000; tx_n its complement; both 0 afterwards.
- No echo -> timeout single pulse 76 cycles after BURST entry (16+10+50 = cycle 75 of LISTEN end); busy drops at period timer 99; no second burst (en=0).
- en=1, echo rising edge 20 cycles into LISTEN -> echo_seen pulse 2 cycles after pulse_r edge (sync latency); no timeout; next pulse_t rises exactly 100 cycles after previous.
- Echo edge during BLANK only -> no echo_seen; timeout still fires at end of LISTEN.
- RSTn low for 1 cycle mid-BURST -> next cycle all outputs 0, state IDLE; start afterwards produces full normal 16-cycle burst.
- start asserted during LISTEN with en=0 -> ignored; exactly one burst observed.
